// File: rtl/aes_stream_pkg.sv
// aes_stream_pkg
// Shared widths, data types and serializer state encoding for the AES
// block/word stream blocks.
//   WORD_W        : width of one output word (32)
//   BLOCK_W       : width of one AES block (128)
//   WORDS_PER_BLK : words per block (4)
//   word_t/block_t: data types for words and blocks
//   ser_state_e   : serializer FSM states {IDLE, SHIFT}
package aes_stream_pkg;
  localparam int WORD_W        = 32;
  localparam int BLOCK_W       = 128;
  localparam int WORDS_PER_BLK = 4;

  typedef logic [WORD_W-1:0]  word_t;
  typedef logic [BLOCK_W-1:0] block_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;
endpackage

// File: rtl/aes_block_buffer.sv
// aes_block_buffer
// Single-entry 128-bit holding register with a full flag. Holds a block that
// arrived while the serializer was still shifting out the previous one.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   i_load       : capture i_data and set full (only issued while empty)
//   i_data       : block to capture
//   i_unload     : release the held block (only issued while full)
//   o_data       : held block
//   o_full       : entry occupied
module aes_block_buffer
  import aes_stream_pkg::*;
(
  input  logic   clk,
  input  logic   reset_n,
  input  logic   i_load,
  input  block_t i_data,
  input  logic   i_unload,
  output block_t o_data,
  output logic   o_full
);

  block_t r_data;
  logic   r_full;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data <= '0;
      r_full <= 1'b0;
    end else begin
      if (i_unload) begin
        r_full <= 1'b0;
      end
      // Load wins over unload; the parent never issues both together.
      if (i_load) begin
        r_data <= i_data;
        r_full <= 1'b1;
      end
    end
  end

  assign o_data = r_data;
  assign o_full = r_full;

endmodule

// File: rtl/aes_block_serializer.sv
// aes_block_serializer
// Accepts 128-bit AES blocks and emits each as four 32-bit words, most
// significant word first. A one-entry pending buffer lets back-to-back
// blocks stream with no bubble between them.
// Optional feature macro: AES_SER_BLKCNT_EN adds the blk_count port, a
// wrapping count of completed blocks.
// Ports:
//   clk, reset_n  : clock, asynchronous active-low reset
//   blk_in        : block data, word 0 = blk_in[127:96]
//   blk_valid     : blk_in valid
//   blk_ready     : block accepted when blk_valid && blk_ready
//   word_out      : current word (0 when idle)
//   word_valid    : word_out valid
//   word_ready    : sink accepts when word_valid && word_ready
//   word_idx      : index of word_out within its block
//   word_last     : high with the last word of a block
//   busy          : shifting or pending buffer occupied
//   blk_count     : completed blocks (AES_SER_BLKCNT_EN only)
//   dbg_state     : current FSM state, for observation
// Handshake: a transfer happens on a rising edge where valid && ready; a
// producer holds valid and data until that edge, and ready depends only on
// registered state (never combinationally on the other side's valid/ready).
module aes_block_serializer
  import aes_stream_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  block_t           blk_in,
  input  logic             blk_valid,
  output logic             blk_ready,
  output word_t            word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic [1:0]       word_idx,
  output logic             word_last,
  output logic             busy,
`ifdef AES_SER_BLKCNT_EN
  output logic [CNT_W-1:0] blk_count,
`endif
  output ser_state_e       dbg_state
);

  ser_state_e r_state, w_state_nxt;
  block_t     r_sreg, w_sreg_nxt;
  logic [1:0] r_cnt, w_cnt_nxt;

  logic   w_pend_full;
  block_t w_pend_data;
  logic   w_acc;
  logic   w_wx;
  logic   w_lx;
  logic   w_direct;
  logic   w_pend_load;
  logic   w_pend_unload;

  assign blk_ready  = !w_pend_full;
  assign word_valid = (r_state == SHIFT);
  assign word_out   = r_sreg[BLOCK_W-1 -: WORD_W];
  assign word_idx   = r_cnt;
  assign word_last  = (r_state == SHIFT) && (r_cnt == 2'd3);
  assign busy       = (r_state == SHIFT) || w_pend_full;
  assign dbg_state  = r_state;

  assign w_acc = blk_valid && blk_ready;
  assign w_wx  = word_valid && word_ready;
  assign w_lx  = w_wx && (r_cnt == 2'd3);

  // An accepted block goes straight into the shift register when nothing is
  // being shifted or the current block finishes this cycle; otherwise it
  // waits in the pending buffer. Pending is empty whenever w_acc is high.
  assign w_direct      = (r_state == IDLE) || w_lx;
  assign w_pend_load   = w_acc && !w_direct;
  assign w_pend_unload = w_lx && w_pend_full;

  aes_block_buffer u_pend (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_load   (w_pend_load),
    .i_data   (blk_in),
    .i_unload (w_pend_unload),
    .o_data   (w_pend_data),
    .o_full   (w_pend_full)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_sreg  <= '0;
      r_cnt   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_sreg  <= w_sreg_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sreg_nxt  = r_sreg;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_acc) begin
          w_sreg_nxt  = blk_in;
          w_cnt_nxt   = 2'd0;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (w_lx) begin
          w_cnt_nxt = 2'd0;
          if (w_pend_full) begin
            w_sreg_nxt = w_pend_data;
          end else if (w_acc) begin
            w_sreg_nxt = blk_in;
          end else begin
            // Clearing sreg keeps word_out at zero while idle.
            w_sreg_nxt  = '0;
            w_state_nxt = IDLE;
          end
        end else if (w_wx) begin
          w_sreg_nxt = {r_sreg[BLOCK_W-WORD_W-1:0], {WORD_W{1'b0}}};
          w_cnt_nxt  = r_cnt + 2'd1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

`ifdef AES_SER_BLKCNT_EN
  logic [CNT_W-1:0] r_blk_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_blk_count <= '0;
    end else if (w_lx) begin
      r_blk_count <= r_blk_count + 1'b1;
    end
  end

  assign blk_count = r_blk_count;
`endif

endmodule

// File: tb/tb_aes_block_serializer.sv
// tb_aes_block_serializer
// Drives aes_block_serializer with directed and random traffic. The reference
// model is a queue of outstanding {index, word} entries: an accepted block
// appends its four words, each word handshake removes the head entry.
module tb_aes_block_serializer;
  import aes_stream_pkg::*;

  localparam int CNT_W = 2;

  logic       clk = 1'b0;
  logic       reset_n;
  block_t     blk_in;
  logic       blk_valid;
  logic       blk_ready;
  word_t      word_out;
  logic       word_valid;
  logic       word_ready;
  logic [1:0] word_idx;
  logic       word_last;
  logic       busy;
  ser_state_e dbg_state;
`ifdef AES_SER_BLKCNT_EN
  logic [CNT_W-1:0] blk_count;
`endif

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  aes_block_serializer #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .blk_in     (blk_in),
    .blk_valid  (blk_valid),
    .blk_ready  (blk_ready),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .word_idx   (word_idx),
    .word_last  (word_last),
    .busy       (busy),
`ifdef AES_SER_BLKCNT_EN
    .blk_count  (blk_count),
`endif
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [33:0] exp_q[$];
  int          completed;
  int          errors;
  int          checks;

  function automatic int outstanding_blocks();
    return (exp_q.size() + 3) / 4;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [33:0] head;
    logic        v;
    v    = (exp_q.size() > 0);
    head = v ? exp_q[0] : 34'h0;
    chk("word_valid", word_valid, v);
    chk("word_out",   word_out,   head[31:0]);
    chk("word_idx",   word_idx,   head[33:32]);
    chk("word_last",  word_last,  v && (head[33:32] == 2'd3));
    chk("blk_ready",  blk_ready,  outstanding_blocks() <= 1);
    chk("busy",       busy,       v);
    chk("dbg_state",  dbg_state,  v ? SHIFT : IDLE);
`ifdef AES_SER_BLKCNT_EN
    chk("blk_count",  blk_count,  completed % (1 << CNT_W));
`endif
  endtask

  // ---------------- driver tasks ----------------
  // One clock cycle: apply inputs, check outputs, advance the model.
  task automatic step(input logic bv, input block_t bd, input logic wr, output bit acc);
    logic [33:0] head;
    blk_valid  = bv;
    blk_in     = bd;
    word_ready = wr;
    #1;
    check_outputs();
    acc = bv && (outstanding_blocks() <= 1);
    if (wr && exp_q.size() > 0) begin
      head = exp_q.pop_front();
      if (head[33:32] == 2'd3) completed++;
    end
    if (acc) begin
      for (int i = 0; i < 4; i++) begin
        exp_q.push_back({2'(i), bd[127-32*i -: 32]});
      end
    end
    @(posedge clk);
    #2;
  endtask

  task automatic send_block(input block_t bd, input logic wr);
    bit acc;
    int tries;
    acc   = 1'b0;
    tries = 0;
    while (!acc && tries < 20) begin
      step(1'b1, bd, wr, acc);
      tries++;
    end
    if (!acc) chk("accept_timeout", 1'b0, 1'b1);
  endtask

  task automatic idle_cycles(input int n, input logic wr);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, '0, wr, acc);
  endtask

  function automatic block_t rand_block();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    bit acc;
    errors     = 0;
    checks     = 0;
    completed  = 0;
    reset_n    = 1'b0;
    blk_valid  = 1'b0;
    blk_in     = '0;
    word_ready = 1'b0;
    #1;
    check_outputs();
    @(posedge clk);
    #2;
    reset_n = 1'b1;

    // Single block, sink always ready.
    send_block(128'h00112233_44556677_8899AABB_CCDDEEFF, 1'b1);
    idle_cycles(6, 1'b1);

    // Three blocks back-to-back.
    send_block(128'h01010101_02020202_03030303_04040404, 1'b1);
    send_block(128'h11111111_22222222_33333333_44444444, 1'b1);
    send_block(128'hA5A5A5A5_5A5A5A5A_DEADBEEF_CAFEF00D, 1'b1);
    idle_cycles(14, 1'b1);

    // Stalls 1,0,0,1 during a block.
    send_block(128'hF0F0F0F0_0F0F0F0F_12345678_9ABCDEF0, 1'b1);
    step(1'b0, '0, 1'b1, acc);
    step(1'b0, '0, 1'b0, acc);
    step(1'b0, '0, 1'b0, acc);
    step(1'b0, '0, 1'b1, acc);
    idle_cycles(4, 1'b1);

    // New block offered exactly on the last-word cycle, pending empty.
    send_block(128'h10203040_50607080_90A0B0C0_D0E0F000, 1'b1);
    idle_cycles(3, 1'b1);
    send_block(128'hCAFEBABE_FEEDFACE_0BADF00D_8BADF00D, 1'b1);
    idle_cycles(6, 1'b1);

    // Reset mid-block with a pending block.
    send_block(128'h0000000A_0000000B_0000000C_0000000D, 1'b0);
    step(1'b0, '0, 1'b1, acc);
    step(1'b1, 128'h1000000A_1000000B_1000000C_1000000D, 1'b1, acc);
    blk_valid = 1'b0;
    reset_n   = 1'b0;
    #1;
    exp_q.delete();
    completed = 0;
    check_outputs();
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    send_block(128'h2000000A_2000000B_2000000C_2000000D, 1'b1);
    idle_cycles(6, 1'b1);

    // Five blocks in a row (counter wrap).
    for (int b = 0; b < 5; b++) send_block(rand_block(), 1'b1);
    idle_cycles(12, 1'b1);

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      step(1'($urandom_range(0, 1)), rand_block(), 1'($urandom_range(0, 3) != 0), acc);
    end
    idle_cycles(12, 1'b1);

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
